// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller.
// Holds the state encodings, the {R,Y,G} light constants, the time_sel codes
// and the default interval width.
package traffic_pkg;

  localparam int TW_DEF = 4;

  typedef enum logic [2:0] {
    S_MG   = 3'd0,
    S_MY   = 3'd1,
    S_WALK = 3'd2,
    S_SG   = 3'd3,
    S_SY   = 3'd4
  } state_t;

  // Lights are {R,Y,G}, one-hot.
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic [1:0] SEL_BASE = 2'd0;
  localparam logic [1:0] SEL_EXT  = 2'd1;
  localparam logic [1:0] SEL_YEL  = 2'd2;
  localparam logic [1:0] SEL_RSVD = 2'd3;

endpackage

// File: rtl/traffic_interval_timer.sv
// interval_timer: loadable TW-bit down-counter used to time each phase.
// Ports:
//   clk      in      rising-edge clock
//   tick     in      timebase enable; decrements while cnt > 0
//   load     in      load load_val (wins over tick)
//   load_val in  TW  value loaded (interval - 1)
//   expired  out     tick seen while cnt == 0 (phase is over)
module interval_timer
  import traffic_pkg::*;
#(
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          tick,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          expired
);

  logic [TW-1:0] cnt;

  // The owner asserts load in its reset cycle, so no local reset is needed.
  always_ff @(posedge clk) begin
    if (load)
      cnt <= load_val;
    else if (tick && (cnt != '0))
      cnt <= cnt - TW'(1);
  end

  assign expired = tick && (cnt == '0);

endmodule

// File: rtl/traffic_fsm.sv
// traffic_fsm: main sequencing FSM of the traffic light controller.
// Cycles MG -> MY -> [WALK] -> SG (one optional extension) -> SY -> MG, with
// phase lengths from a reprogrammable base/ext/yellow interval register set.
// Optional feature macro: TRAFFIC_WALK_EN enables the pedestrian WALK phase;
// without it wr_sync is ignored and walk_lamp stays 0.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   tick                one-cycle timebase enable
//   sensor_sync         side-street vehicle present
//   wr_sync             pedestrian walk request
//   prog_sync           interval write strobe (also restarts at S_MG)
//   time_sel[1:0]       0 base, 1 ext, 2 yellow, 3 reserved
//   time_value[TW-1:0]  interval to write (0 stored as 1)
//   main_lights[2:0]    main street {R,Y,G}
//   side_lights[2:0]    side street {R,Y,G}
//   walk_lamp           walk indicator
//   state_out[2:0]      current state encoding
module traffic_fsm
  import traffic_pkg::*;
#(
  parameter int T_BASE = 6,
  parameter int T_EXT  = 3,
  parameter int T_YEL  = 2,
  parameter int TW     = TW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          sensor_sync,
  input  logic          wr_sync,
  input  logic          prog_sync,
  input  logic [1:0]    time_sel,
  input  logic [TW-1:0] time_value,
  output logic [2:0]    main_lights,
  output logic [2:0]    side_lights,
  output logic          walk_lamp,
  output logic [2:0]    state_out
);

`ifdef TRAFFIC_WALK_EN
  localparam bit WALK_EN = 1'b1;
`else
  localparam bit WALK_EN = 1'b0;
`endif

  state_t        state, next_state;
  logic [TW-1:0] t_base, t_ext, t_yel;
  logic [TW-1:0] prog_val, new_base;
  logic [TW-1:0] tmr_val;
  logic          tmr_load, expired;
  logic          ext_done, ext_grant;
  logic          walk_pending;
  logic [2:0]    main_d, side_d;
  logic          walk_d;

  // A zero interval would mean a zero-length phase; clamp to one tick.
  assign prog_val = (time_value == '0) ? TW'(1) : time_value;
  // The restart after a write must already see the freshly written base.
  assign new_base = (time_sel == SEL_BASE) ? prog_val : t_base;

  always_ff @(posedge clk) begin
    if (reset) begin
      t_base <= TW'(T_BASE);
      t_ext  <= TW'(T_EXT);
      t_yel  <= TW'(T_YEL);
    end else if (prog_sync) begin
      case (time_sel)
        SEL_BASE: t_base <= prog_val;
        SEL_EXT:  t_ext  <= prog_val;
        SEL_YEL:  t_yel  <= prog_val;
        default:  ;
      endcase
    end
  end

  interval_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .tick     (tick),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (expired)
  );

  assign ext_grant = sensor_sync && !ext_done;

  always_ff @(posedge clk) begin
    if (reset || prog_sync)
      ext_done <= 1'b0;
    else if (expired && (state == S_SG))
      ext_done <= ext_grant;  // set when extending, cleared when leaving
  end

`ifdef TRAFFIC_WALK_EN
  logic walk_enter;
  assign walk_enter = (next_state == S_WALK) && (state != S_WALK);

  // Entry clears the flag even if wr_sync is high in that same cycle.
  always_ff @(posedge clk) begin
    if (reset)
      walk_pending <= 1'b0;
    else if (walk_enter)
      walk_pending <= 1'b0;
    else if (wr_sync && (state != S_WALK))
      walk_pending <= 1'b1;
  end
`else
  logic unused_wr;
  assign unused_wr    = wr_sync;
  assign walk_pending = 1'b0;
`endif

  // State and registered outputs update on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_MG;
      main_lights <= GRN;
      side_lights <= RED;
      walk_lamp   <= 1'b0;
    end else begin
      state       <= next_state;
      main_lights <= main_d;
      side_lights <= side_d;
      walk_lamp   <= walk_d;
    end
  end

  assign state_out = state;

  // Next state plus the counter reload for the phase being entered.
  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_val    = t_base - TW'(1);
    if (reset) begin
      next_state = S_MG;
      tmr_load   = 1'b1;
      tmr_val    = TW'(T_BASE - 1);
    end else if (prog_sync) begin
      next_state = S_MG;
      tmr_load   = 1'b1;
      tmr_val    = new_base - TW'(1);
    end else if (expired) begin
      tmr_load = 1'b1;
      case (state)
        S_MG: begin
          next_state = S_MY;
          tmr_val    = t_yel - TW'(1);
        end
        S_MY: begin
          if (walk_pending) begin
            next_state = S_WALK;
            tmr_val    = t_ext - TW'(1);
          end else begin
            next_state = S_SG;
          end
        end
        S_WALK: next_state = S_SG;
        S_SG: begin
          if (ext_grant) begin
            tmr_val = t_ext - TW'(1);
          end else begin
            next_state = S_SY;
            tmr_val    = t_yel - TW'(1);
          end
        end
        S_SY:    next_state = S_MG;
        default: next_state = S_MG;
      endcase
    end
  end

  // Light decode of the state being entered, registered above.
  always_comb begin
    main_d = RED;
    side_d = RED;
    walk_d = 1'b0;
    case (next_state)
      S_MG:    main_d = GRN;
      S_MY:    main_d = YEL;
      S_WALK:  walk_d = WALK_EN;
      S_SG:    side_d = GRN;
      S_SY:    side_d = YEL;
      default: main_d = GRN;
    endcase
  end

endmodule

// File: doc/traffic_fsm.md
# traffic_fsm

Main sequencing state machine of the traffic light controller. It consumes the already-synchronized `reset`, `sensor_sync`, `wr_sync` and `prog_sync` signals from the synchronizer, plus a one-cycle timebase `tick` from the clock divider. It drives the main-street lights, side-street lights and walk lamp. Phase durations live in a small reprogrammable interval register set.

## Interface
- `T_BASE`, default 6: reset value of base green interval, in ticks.
- `T_EXT`, default 3: reset value of extension/walk interval, in ticks.
- `T_YEL`, default 2: reset value of yellow interval, in ticks.
- `TW`, default 4: width of intervals and down-counter.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `tick` in 1: timebase enable, one-cycle pulse.
- `sensor_sync` in 1: side-street vehicle present.
- `wr_sync` in 1: pedestrian walk request.
- `prog_sync` in 1: interval write strobe.
- `time_sel` in 2: interval select. 0 = base, 1 = ext, 2 = yel, 3 = reserved.
- `time_value` in TW: interval value to write.
- `main_lights` out 3: {R,Y,G}, one-hot.
- `side_lights` out 3: {R,Y,G}, one-hot.
- `walk_lamp` out 1: walk indicator.
- `state_out` out 3: current state encoding, for debug.

## Operation
- States and their lights:
  - S_MG: main G, side R.
  - S_MY: main Y, side R.
  - S_WALK: both R, walk_lamp 1.
  - S_SG: main R, side G.
  - S_SY: main R, side Y.
- Down-counter `cnt` is loaded with interval−1 on state entry. Each `tick` decrements it. On a `tick` with `cnt==0` the phase expires.
- Transitions on expiry:
  - S_MG (t_base) → S_MY.
  - S_MY (t_yel) → S_WALK if `walk_pending`, else S_SG.
  - S_WALK (t_ext) → S_SG.
  - S_SG (t_base): if `sensor_sync`=1 on the expiry tick and not yet extended, reload t_ext−1, set `ext_done`, stay in S_SG. Otherwise → S_SY. `ext_done` clears on leaving S_SG.
  - S_SY (t_yel) → S_MG.
- Only one side-green extension is granted per cycle of the sequence.
- `walk_pending`:
  - Set by `wr_sync`=1 in any state except S_WALK; requests during S_WALK are ignored.
  - Cleared on the transition into S_WALK.
  - Preserved across reprogramming.
- Reprogram: `prog_sync`=1 writes `time_value` into the register chosen by `time_sel`.
  - `time_sel`=3 ignored.
  - `time_value`=0 is stored as 1.
  - Any `prog_sync`=1 cycle, including `time_sel`=3, forces S_MG with `cnt` loaded from the new value set and clears `ext_done`.
- Priority: `reset` > `prog_sync` > expiry > hold.
- `tick`=0: state and `cnt` hold.
- Intervals are unsigned TW-bit. Maximum phase length is 2^TW−1 ticks. No wrap: a decrement occurs only while `cnt`>0.

## Timing
- Reset values:
  - state S_MG, `cnt`=T_BASE−1.
  - `main_lights`=001, `side_lights`=100, `walk_lamp`=0, `state_out`=S_MG.
  - `walk_pending`=0, `ext_done`=0.
  - Interval registers = parameter values.
- Outputs are registered and change on the same edge as the state register (Moore). Latency from expiry tick to new lights is 1 clock.
- A `prog_sync` write is visible on the next edge. The first phase after reprogramming uses the new values.
- Reset mid-phase: outputs take reset values on the next edge regardless of state.
- `wr_sync` and S_WALK entry in the same cycle: entry clears the flag; the request is dropped.

## Configuration
- `TRAFFIC_WALK_EN` defined: S_WALK, `walk_pending` and `walk_lamp` drive as above.
- Undefined:
  - S_WALK is absent; S_MY → S_SG always.
  - `wr_sync` is ignored.
  - `walk_lamp` is tied 0.
  - The port list is unchanged.

## Structure
- Package `traffic_pkg` holds:
  - State encodings S_MG..S_SY.
  - Light constants RED=100, YEL=010, GRN=001.
  - `time_sel` codes.
  - Default TW.
- Sub-module `interval_timer` contains the loadable TW-bit down-counter with `tick` enable, `load`/`load_val` and an `expired` output. The FSM, interval registers and walk flag stay in `traffic_fsm`.

## Test plan
All scenarios use T_BASE=6, T_EXT=3, T_YEL=2 and `tick`=1 every cycle unless stated.
- **Free-running sequence:** reset, then no sensor and no walk → MG 6, MY 2, SG 6, SY 2 cycles; period 16; lights one-hot throughout.
- **Side-green extension:** `sensor_sync` held 1 → SG lasts 9 cycles exactly once per sequence, then SY.
- **Walk request:** `wr_sync` pulse during MG → after MY, WALK 3 cycles with both R and `walk_lamp`=1, then SG. A second pulse during WALK does not cause another WALK.
- **Reprogramming:**
  - `prog_sync` with `time_sel`=0, `time_value`=4 mid-SG → next edge S_MG; MG lasts 4.
  - `time_value`=0 → MG lasts 1.
  - `time_sel`=3 → intervals unchanged, FSM restarts at S_MG.
- **Reset mid-phase:** reset in SY while `walk_pending`=1 → next edge S_MG, `main_lights`=001, `side_lights`=100, `walk_pending`=0.
- **Tick gating:** `tick` every 4th cycle → MG lasts 24 clocks; state frozen between ticks.
